fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/branch-resolution logic.
- Owns the PC, issues one instruction-memory request at a time, and registers fetched instructions into the IF/ID outputs.
- Consumes the takebranch/target redirect and the hazard stall, flushing wrong-path instructions on redirect.

---
 rtl/fetch_stage.sv | 192 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with a single outstanding imem request.
// Owns the PC, registers fetched instructions into IF/ID, honours the hazard
// stall through a one-entry hold buffer and flushes wrong-path fetches on a
// branch redirect.
// Optional build macro FETCH_PERF_CNT_EN adds redirect_count / fetch_count.
//
// state | meaning
// REQ   | request for pc_q presented to imem, waiting for acceptance
// WAIT  | request accepted, waiting for its response (kill drops it)
// HOLD  | response parked in hold buffer while IF/ID is stalled
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               takebranch,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               stall,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_id_valid,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        redirect_count,
    output logic [31:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_e;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      inflight_pc_q, inflight_pc_d;
    logic                 kill_q, kill_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [XLEN-1:0]      hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0]      if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0]   if_id_instr_q, if_id_instr_d;

    logic                 req_fire;
    logic                 load;
    logic [XLEN-1:0]      load_pc;
    logic [INSTR_W-1:0]   load_instr;

    // A redirect in the same cycle suppresses the request so the old PC is never issued.
    assign imem_req_valid = (state_q == ST_REQ) && !takebranch && !reset;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;

    // Next-state, PC, hold buffer and IF/ID advance; redirect takes priority.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        kill_d        = kill_q;
        hold_valid_d  = hold_valid_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        load          = 1'b0;
        load_pc       = inflight_pc_q;
        load_instr    = imem_rsp_data;

        if (takebranch) begin
            pc_d          = {branch_target[XLEN-1:2], 2'b00};
            if_id_valid_d = 1'b0;
            hold_valid_d  = 1'b0;
            if (state_q == ST_WAIT && !imem_rsp_valid) begin
                // Response still owed for the wrong-path request: drop it on arrival.
                kill_d  = 1'b1;
                state_d = ST_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + XLEN'(4);
                        state_d       = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (!stall || !if_id_valid_q) begin
                            load    = 1'b1;
                            state_d = ST_REQ;
                        end else begin
                            hold_valid_d = 1'b1;
                            hold_pc_d    = inflight_pc_q;
                            hold_instr_d = imem_rsp_data;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        load         = 1'b1;
                        load_pc      = hold_pc_q;
                        load_instr   = hold_instr_q;
                        hold_valid_d = 1'b0;
                        state_d      = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase

            if (load) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = load_pc;
                if_id_instr_d = load_instr;
            end else if (!stall) begin
                if_id_valid_d = 1'b0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_pc_q     <= '0;
            hold_instr_q  <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            hold_valid_q  <= hold_valid_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_count_q, redirect_count_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    assign redirect_count = redirect_count_q;
    assign fetch_count    = fetch_count_q;

    // Free-running event counters, wrapping at 2^32.
    always_comb begin
        redirect_count_d = redirect_count_q;
        fetch_count_d    = fetch_count_q;
        if (takebranch) redirect_count_d = redirect_count_q + 32'd1;
        if (load)       fetch_count_d    = fetch_count_q + 32'd1;
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_count_q <= '0;
            fetch_count_q    <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
            fetch_count_q    <= fetch_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural imem model with programmable
// latency, scoreboard of expected IF/ID loads, immediate-assertion checks.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        takebranch;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_count;
    logic [31:0] fetch_count;
`endif

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .takebranch     (takebranch),
        .branch_target  (branch_target),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_count (redirect_count),
        .fetch_count    (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    // memory model state
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    int          lat      = 1;
    bit          ovr_en   = 1'b0;
    logic [31:0] ovr_addr = '0;
    logic [31:0] ovr_data = '0;

    // values seen during the most recent cycle
    logic        last_req_valid;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    // One clock cycle with the inputs currently applied; returns just after the next negedge.
    task automatic tick();
        logic acc;
        logic pre_valid;
        logic pre_stall;
        logic rsp_given;
        exp_t e;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_busy && mem_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
        end
        #1;
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        acc            = imem_req_valid && imem_req_ready;
        pre_valid      = if_id_valid;
        pre_stall      = stall;
        rsp_given      = imem_rsp_valid;
        @(posedge clk);
        @(negedge clk);
        if (reset) begin
            mem_busy = 1'b0;
        end else begin
            if (rsp_given) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (acc) begin
                mem_busy = 1'b1;
                mem_cnt  = lat;
                mem_addr = last_req_addr;
            end
        end
        if (if_id_valid && (!pre_valid || !pre_stall)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed pc=%h instr=%h expected no load", if_id_pc, if_id_instr);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", if_id_pc, e.pc);
                chk("sb_instr", if_id_instr, e.instr);
            end
        end
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset          = 1'b1;
        takebranch     = 1'b0;
        branch_target  = '0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // reset state
        tick();
        chk("rst_req_valid", {31'd0, last_req_valid}, 32'd0);
        tick();
        chk("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_if_id_pc", if_id_pc, 32'd0);
        chk("rst_if_id_instr", if_id_instr, 32'd0);
        reset = 1'b0;

        // streaming fetch, 1-cycle memory, ready stall at 0x1004
        lat = 1;
        push(32'h1000); push(32'h1004); push(32'h1008);
        tick();
        chk("first_req_valid", {31'd0, last_req_valid}, 32'd1);
        chk("first_req_addr", last_req_addr, 32'h1000);
        chk("lat_valid0", {31'd0, if_id_valid}, 32'd0);
        tick();
        chk("lat_valid1", {31'd0, if_id_valid}, 32'd1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nrdy_valid", {31'd0, last_req_valid}, 32'd1);
            chk("nrdy_addr", last_req_addr, 32'h1004);
        end
        chk("nrdy_bubble", {31'd0, if_id_valid}, 32'd0);
        imem_req_ready = 1'b1;
        tick();
        chk("acc_addr_1004", last_req_addr, 32'h1004);
        chk("alt_valid_a", {31'd0, if_id_valid}, 32'd0);
        tick();
        chk("alt_valid_b", {31'd0, if_id_valid}, 32'd1);
        tick();
        chk("acc_addr_1008", last_req_addr, 32'h1008);
        chk("alt_valid_c", {31'd0, if_id_valid}, 32'd0);
        tick();
        chk("alt_valid_d", {31'd0, if_id_valid}, 32'd1);
        chk("sb_drained_1", 32'(sb.size()), 32'd0);

        // stall with valid IF/ID while response arrives -> hold buffer
        ovr_en   = 1'b1;
        ovr_addr = 32'h100C;
        ovr_data = 32'hDEAD_BEEF;
        push(32'h100C);
        stall = 1'b1;
        tick();
        chk("hold_req_addr", last_req_addr, 32'h100C);
        chk("hold_keep_pc0", if_id_pc, 32'h1008);
        tick();
        chk("hold_keep_valid", {31'd0, if_id_valid}, 32'd1);
        chk("hold_keep_pc", if_id_pc, 32'h1008);
        chk("hold_keep_instr", if_id_instr, 32'h1008 ^ 32'hA5A5_5A5A);
        tick();
        chk("hold_no_req", {31'd0, last_req_valid}, 32'd0);
        chk("hold_keep_pc2", if_id_pc, 32'h1008);
        stall = 1'b0;
        tick();
        chk("hold_no_req2", {31'd0, last_req_valid}, 32'd0);
        chk("hold_out_instr", if_id_instr, 32'hDEAD_BEEF);
        chk("hold_out_pc", if_id_pc, 32'h100C);
        ovr_en = 1'b0;

        // redirect while WAIT, response 3 cycles after acceptance is killed
        lat = 3;
        tick();
        chk("kill_req_addr", last_req_addr, 32'h1010);
        takebranch    = 1'b1;
        branch_target = 32'h2002;
        tick();
        chk("tb_req_blocked", {31'd0, last_req_valid}, 32'd0);
        takebranch = 1'b0;
        tick();
        chk("kill_wait_noreq", {31'd0, last_req_valid}, 32'd0);
        tick();
        chk("kill_drop_valid", {31'd0, if_id_valid}, 32'd0);
        push(32'h2000);
        tick();
        chk("redir_req_valid", {31'd0, last_req_valid}, 32'd1);
        chk("redir_req_addr", last_req_addr, 32'h2000);
        wait_drain(8);

        // redirect coincident with response (and stall): no kill left pending
        lat = 2;
        tick();
        chk("same_req_addr", last_req_addr, 32'h2004);
        tick();
        takebranch    = 1'b1;
        branch_target = 32'h2000;
        stall         = 1'b1;
        tick();
        chk("same_flush_valid", {31'd0, if_id_valid}, 32'd0);
        takebranch = 1'b0;
        stall      = 1'b0;
        push(32'h2000);
        tick();
        chk("same_next_valid", {31'd0, last_req_valid}, 32'd1);
        chk("same_next_addr", last_req_addr, 32'h2000);
        wait_drain(8);

        // four more fetches -> ten loads in total
        lat = 1;
        push(32'h2004); push(32'h2008); push(32'h200C); push(32'h2010);
        wait_drain(20);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd10);
        chk("redirect_count", redirect_count, 32'd2);
`endif

        // synchronous reset mid-run
        reset = 1'b1;
        tick();
        chk("rst2_req_valid", {31'd0, last_req_valid}, 32'd0);
        chk("rst2_if_id_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst2_fetch_count", fetch_count, 32'd0);
        chk("rst2_redirect_count", redirect_count, 32'd0);
`endif
        reset = 1'b0;
        push(32'h1000);
        tick();
        chk("rst2_req_addr", last_req_addr, 32'h1000);
        wait_drain(8);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
